// File: rtl/decode_stage.sv
// Decode stage: register file, immediate extension, load-use stall and ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle WB write to the ID read ports.
module decode_stage #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    parameter int CTRL_W   = 16,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       instruction,
    input  logic [XLEN-1:0]   pc_in,
    input  logic              Reg2Loc,
    input  logic [1:0]        imm_sel,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              mem_read_in,
    input  logic              flush,
    input  logic              RegWrite,
    input  logic [AW-1:0]     write_register,
    input  logic [XLEN-1:0]   write_back,
    input  logic              Branchlink,
    input  logic [XLEN-1:0]   PC_branch_link_in,
    output logic              stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_read_data1,
    output logic [XLEN-1:0]   ex_read_data2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [AW-1:0]     ex_rn,
    output logic [AW-1:0]     ex_rm2,
    output logic [AW-1:0]     ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read
);

    localparam logic [AW-1:0] XZR = AW'(NUM_REGS - 1);

    logic [XLEN-1:0] r_regs [NUM_REGS];

    logic [AW-1:0]   w_rd;
    logic [AW-1:0]   w_rn;
    logic [AW-1:0]   w_rm;
    logic [AW-1:0]   w_rreg2;
    logic [XLEN-1:0] w_wdata;
    logic            w_we;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic [XLEN-1:0] w_imm;
    logic            w_hz;
    logic            w_unused;

    assign w_rd     = AW'(instruction[4:0]);
    assign w_rn     = AW'(instruction[9:5]);
    assign w_rm     = AW'(instruction[20:16]);
    assign w_rreg2  = Reg2Loc ? w_rd : w_rm;
    assign w_wdata  = Branchlink ? PC_branch_link_in : write_back;
    assign w_we     = RegWrite && (write_register != XZR);
    assign w_unused = ^instruction[31:26];

    function automatic logic [XLEN-1:0] rf_read(input logic [AW-1:0] a);
        if (a == XZR) return '0;
`ifdef ID_WB_BYPASS_EN
        if (w_we && (write_register == a)) return w_wdata;
`endif
        return r_regs[a];
    endfunction

    assign w_rdata1 = rf_read(w_rn);
    assign w_rdata2 = rf_read(w_rreg2);

    // Shifted formats extend first, then shift; overflow above XLEN is dropped.
    always_comb begin
        w_imm = '0;
        unique case (imm_sel)
            2'd0: w_imm = {{(XLEN-12){1'b0}}, instruction[21:10]};
            2'd1: w_imm = {{(XLEN-9){instruction[20]}}, instruction[20:12]};
            2'd2: w_imm = {{(XLEN-19){instruction[23]}}, instruction[23:5]} << 2;
            2'd3: w_imm = {{(XLEN-26){instruction[25]}}, instruction[25:0]} << 2;
        endcase
    end

    assign w_hz = if_valid && ex_valid && ex_mem_read && (ex_rd != XZR)
                  && ((ex_rd == w_rn) || (ex_rd == w_rreg2));
    assign stall = w_hz && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[write_register] <= w_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset || flush || w_hz) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_rn         <= '0;
            ex_rm2        <= '0;
            ex_rd         <= '0;
            ex_ctrl       <= '0;
            ex_mem_read   <= 1'b0;
        end else begin
            ex_valid      <= if_valid;
            ex_pc         <= pc_in;
            ex_read_data1 <= w_rdata1;
            ex_read_data2 <= w_rdata2;
            ex_imm        <= w_imm;
            ex_rn         <= w_rn;
            ex_rm2        <= w_rreg2;
            ex_rd         <= w_rd;
            ex_ctrl       <= if_valid ? ctrl_in : '0;
            ex_mem_read   <= if_valid && mem_read_in;
        end
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised successor to the single-cycle decode logic for the pipelined ARMv8 core. Holds the register file, the Reg2Loc and branch-link write muxes, and immediate extension, and adds three things: an ID/EX pipeline register, load-use hazard detection with bubble insertion, and flush support. It sits between the IF/ID register and the execute stage, and takes its write-back port from MEM/WB.

## Interface
- XLEN, 64: data and PC width.
- NUM_REGS, 32: register count; address width AW = $clog2(NUM_REGS); index NUM_REGS-1 is XZR.
- CTRL_W, 16: width of the opaque control bundle passed to EX.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- if_valid  in  1  IF/ID holds a live instruction.
- instruction  in  32  IF/ID instruction; Rd=[4:0], Rn=[9:5], Rm=[20:16].
- pc_in  in  XLEN  IF/ID PC.
- Reg2Loc  in  1  1: read port 2 uses Rd; 0: read port 2 uses Rm.
- imm_sel  in  2  immediate format: 0=I [21:10] zero-ext; 1=D [20:12] sign-ext; 2=CB [23:5] sign-ext, <<2; 3=B [25:0] sign-ext, <<2.
- ctrl_in  in  CTRL_W  decoded control for this instruction.
- mem_read_in  in  1  instruction is a load.
- flush  in  1  kill the instruction in ID (taken branch).
- RegWrite  in  1  WB write enable.
- write_register  in  AW  WB destination.
- write_back  in  XLEN  WB data.
- Branchlink  in  1  1: write PC_branch_link_in instead of write_back.
- PC_branch_link_in  in  XLEN  link value (PC+4).
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX holds a live instruction.
- ex_pc, ex_read_data1, ex_read_data2, ex_imm  out  XLEN  registered operands.
- ex_rn, ex_rm2, ex_rd  out  AW  registered register indices (ex_rm2 = selected port-2 index).
- ex_ctrl  out  CTRL_W  registered control.
- ex_mem_read  out  1  registered load flag.

## Operation
- Register file: NUM_REGS x XLEN.
  - Written on the rising clock edge when RegWrite=1 and write_register≠NUM_REGS-1.
  - Reads are combinational. A read of XZR always returns 0.
- Write data = Branchlink ? PC_branch_link_in : write_back.
- Load-use hazard condition: hz = if_valid & ex_valid & ex_mem_read & ex_rd≠XZR & (ex_rd==Rn | ex_rd==rreg2).
- stall = hz & ~flush. Stall is combinational.
- ID/EX update at each rising edge, in priority order:
  - reset: all ex_* outputs = 0.
  - flush or hz: bubble. ex_valid=0, ex_ctrl=0, ex_mem_read=0; the other ex_* fields are don't-care, and are driven 0.
  - else: load the current operands, immediate, indices, pc_in and ctrl_in. ex_valid=if_valid. ex_ctrl and ex_mem_read are forced to 0 when if_valid=0.
- Flush overrides the hazard: the killed instruction is not stalled.
- Immediate arithmetic:
  - Sign extension replicates the field MSB up to XLEN.
  - The <<2 shift is applied after extension.
  - Bits above XLEN are discarded.

## Timing
- Latency: 1 cycle from IF/ID inputs to ex_* outputs.
- A stall lasts exactly 1 cycle per load-use pair. The bubble clears ex_mem_read, so hz drops the following cycle.
- Register file reset: asynchronous, all entries 0.
- Reset asserted mid-operation: ex_valid drops immediately and stall goes to 0 (ex_valid=0).
- A simultaneous WB write and ID read of the same register is governed by ID_WB_BYPASS_EN.

## Configuration
- ID_WB_BYPASS_EN
  - Defined: a read whose index matches a same-cycle write (RegWrite=1, non-XZR) returns the write data, so ID/EX captures the new value.
  - Undefined: the read returns the pre-write value. Guaranteeing a 3-instruction gap is the compiler's responsibility. Hazard logic is unchanged.

## Test plan
- Reset: hold reset=0 with any inputs -> all ex_*=0, stall=0. Every register reads 0 after release.
- Write/read: write X3=0x1234 via WB, then decode ADD Rn=3 -> ex_read_data1=0x1234 one cycle later.
- XZR and Branchlink:
  - Writing X31 leaves it reading 0.
  - Branchlink=1 with PC_branch_link_in=0x400 writes 0x400, ignoring write_back.
- Load-use: EX holds a load (ex_rd=5), ID has Rm=5 with Reg2Loc=0 -> stall=1 for exactly 1 cycle, bubble in ID/EX; the next cycle loads normally.
- Flush vs hazard: same setup plus flush=1 -> stall=0, bubble, instruction dropped.
- Immediate and bypass:
  - imm_sel=2 with field 0x7FFFF -> ex_imm=0xFFFFFFFFFFFFFFFC.
  - Same-cycle WB of X7=0xAA while reading X7 -> ex_read_data1=0xAA with ID_WB_BYPASS_EN defined, the old value without it.
